arbiter_rr: RTL and testbench

- Next-generation N-master to 1-slave arbiter for the SoC memory protocol: master drives addr/wdata, raises valid (wen nonzero = write, wen zero = read); slave raises ready, combinationally allowed.
- Adds parametrised address/data width and a selectable round-robin or fixed-priority policy.
- Grants are registered and held until the granted master drops valid.
- Back-to-back handover to the next master happens without an idle cycle.
- Sits between CPU/DMA/video masters and a shared memory or peripheral bus.

---
 rtl/arbiter_rr.sv | 164 ++++++++++++++++
 tb/tb_arbiter_rr.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_rr
// Description : N-master to 1-slave memory-protocol arbiter. Selectable
//               round-robin or fixed-priority (highest index wins) policy,
//               registered grant held until the owner drops valid, and
//               bubble-free handover to the next requester.
//               Optional watchdog: define ARBITER_TIMEOUT_EN to abort a
//               slave access stalled for TIMEOUT_CYCLES and set sticky err.
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter_rr #(
    parameter int MASTER_IFACE_CNT = 2,
    parameter int ADDR_W           = 32,
    parameter int DATA_W           = 32,
    parameter int ROUND_ROBIN      = 1,
    parameter int TIMEOUT_CYCLES   = 255,
    localparam int c_BE_W          = DATA_W / 8,
    localparam int c_GW            = (MASTER_IFACE_CNT > 1) ? $clog2(MASTER_IFACE_CNT) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [ADDR_W*MASTER_IFACE_CNT-1:0] addr,
    input  logic [DATA_W*MASTER_IFACE_CNT-1:0] wdata,
    output logic [DATA_W*MASTER_IFACE_CNT-1:0] rdata,
    input  logic [MASTER_IFACE_CNT-1:0]        valid,
    input  logic [c_BE_W*MASTER_IFACE_CNT-1:0] wen,
    output logic [MASTER_IFACE_CNT-1:0]        ready,
    output logic [c_GW-1:0]                    currmaster,
    output logic                               busy,
    output logic [ADDR_W-1:0]                  s_addr,
    output logic [DATA_W-1:0]                  s_wdata,
    input  logic [DATA_W-1:0]                  s_rdata,
    output logic                               s_valid,
    output logic [c_BE_W-1:0]                  s_wen,
    input  logic                               s_ready,
    output logic                               err
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            r_state;
    logic [c_GW-1:0]   r_grant;
    logic [c_GW-1:0]   r_last;
    logic [c_GW-1:0]   w_win;
    logic              w_any;
    logic              w_gvalid;
    logic              w_granted;
    logic              w_release;
    logic              w_abort;

    assign w_any     = |valid;
    assign w_gvalid  = valid[r_grant];
    assign w_granted = (r_state == ST_GRANT);
    assign w_release = w_granted & ~w_gvalid;

    // Winner over the live valid vector; later loop hits override earlier ones,
    // so the RR loop runs from the farthest slot back to last+1.
    always_comb begin
        w_win = '0;
        if (ROUND_ROBIN != 0) begin
            for (int k = MASTER_IFACE_CNT; k >= 1; k--) begin
                if (valid[(int'(r_last) + k) % MASTER_IFACE_CNT])
                    w_win = c_GW'((int'(r_last) + k) % MASTER_IFACE_CNT);
            end
        end else begin
            for (int i = 0; i < MASTER_IFACE_CNT; i++) begin
                if (valid[i])
                    w_win = c_GW'(i);
            end
        end
    end

    // Grant FSM: grant from IDLE, hold while owner requests, regrant or idle on release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= c_GW'(MASTER_IFACE_CNT - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_win;
                        r_last  <= w_win;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!w_gvalid) begin
                        if (w_any) begin
                            r_grant <= w_win;
                            r_last  <= w_win;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ARBITER_TIMEOUT_EN
    localparam int c_CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CW-1:0] r_cnt;
    logic            r_abort;
    logic            r_err;

    // Stall watchdog: counts slave stall cycles of the current grant and aborts at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_abort <= 1'b0;
            r_err   <= 1'b0;
        end else if (!w_granted || w_release) begin
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else if (s_ready) begin
            r_cnt   <= '0;
        end else if (s_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_CW'(TIMEOUT_CYCLES - 1)) begin
                r_abort <= 1'b1;
                r_err   <= 1'b1;
            end
        end
    end

    assign w_abort = r_abort;
    assign err     = r_err;
`else
    assign w_abort = 1'b0;
    assign err     = 1'b0;
`endif

    // Slave side follows the registered grant only, never a non-granted valid.
    assign s_addr  = addr[r_grant*ADDR_W +: ADDR_W];
    assign s_wdata = wdata[r_grant*DATA_W +: DATA_W];
    assign s_wen   = wen[r_grant*c_BE_W +: c_BE_W];
    assign s_valid = w_granted & w_gvalid & ~w_abort;

    assign currmaster = r_grant;
    assign busy       = w_granted;

    // Completion routed to the owner only; an aborted grant completes on its own.
    always_comb begin
        ready = '0;
        if (w_granted)
            ready[r_grant] = w_abort | s_ready;
    end

    // Read data is broadcast; aborted accesses return all-ones.
    always_comb begin
        for (int i = 0; i < MASTER_IFACE_CNT; i++)
            rdata[i*DATA_W +: DATA_W] = w_abort ? {DATA_W{1'b1}} : s_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbiter_rr
// Description : Scoreboard bench for arbiter_rr. Two 3-master instances:
//               d=0 round-robin, d=1 fixed priority. Stimulus queues master
//               transactions and pushes the hand-ordered expected grants;
//               a monitor pops one entry per master handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_rr;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam logic [31:0] RK = 32'h5A5A_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wen;
        bit          gap;
    } txn_t;

    typedef struct {
        int          g;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wen;
        bit          abort;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst        [2];
    logic [N*AW-1:0]   addr       [2];
    logic [N*DW-1:0]   wdata      [2];
    logic [N*DW-1:0]   rdata      [2];
    logic [N-1:0]      valid      [2];
    logic [N*BW-1:0]   wen        [2];
    logic [N-1:0]      ready      [2];
    logic [1:0]        currmaster [2];
    logic              busy       [2];
    logic [AW-1:0]     s_addr     [2];
    logic [DW-1:0]     s_wdata    [2];
    logic [DW-1:0]     s_rdata    [2];
    logic              s_valid    [2];
    logic [BW-1:0]     s_wen      [2];
    logic              s_ready    [2];
    logic              err        [2];

    int   slat [2];
    int   scnt [2];
    bit   tog  [2];
    txn_t mq [2][N][$];
    exp_t sq [2][$];
    int   n_tests = 0;
    int   n_fail  = 0;

    arbiter_rr #(.MASTER_IFACE_CNT(N), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(4)) u_rr (
        .clk(clk), .reset(rst[0]), .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]),
        .valid(valid[0]), .wen(wen[0]), .ready(ready[0]), .currmaster(currmaster[0]),
        .busy(busy[0]), .s_addr(s_addr[0]), .s_wdata(s_wdata[0]), .s_rdata(s_rdata[0]),
        .s_valid(s_valid[0]), .s_wen(s_wen[0]), .s_ready(s_ready[0]), .err(err[0])
    );

    arbiter_rr #(.MASTER_IFACE_CNT(N), .ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(4)) u_fp (
        .clk(clk), .reset(rst[1]), .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]),
        .valid(valid[1]), .wen(wen[1]), .ready(ready[1]), .currmaster(currmaster[1]),
        .busy(busy[1]), .s_addr(s_addr[1]), .s_wdata(s_wdata[1]), .s_rdata(s_rdata[1]),
        .s_valid(s_valid[1]), .s_wen(s_wen[1]), .s_ready(s_ready[1]), .err(err[1])
    );

    // Slave model: answers slat cycles after s_valid rises, returns addr ^ RK.
    assign s_ready[0] = s_valid[0] && (scnt[0] >= slat[0]);
    assign s_ready[1] = s_valid[1] && (scnt[1] >= slat[1]);
    assign s_rdata[0] = s_addr[0] ^ RK;
    assign s_rdata[1] = s_addr[1] ^ RK;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d])                          scnt[d] <= 0;
            else if (s_valid[d] && !s_ready[d])  scnt[d] <= scnt[d] + 1;
            else                                 scnt[d] <= 0;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic present(input int d, input int m);
        txn_t t;
        t = mq[d][m][0];
        addr[d][m*AW +: AW]  = t.addr;
        wdata[d][m*DW +: DW] = t.wdata;
        wen[d][m*BW +: BW]   = t.wen;
        valid[d][m]          = 1'b1;
    endtask

    // Master models: keep valid until handshake, then next txn back-to-back or after a gap.
    initial begin : p_masters
        bit hs [2][N];
        for (int d = 0; d < 2; d++) begin
            valid[d] = '0; addr[d] = '0; wdata[d] = '0; wen[d] = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                for (int m = 0; m < N; m++)
                    hs[d][m] = valid[d][m] && ready[d][m];
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (rst[d]) begin
                    valid[d] = '0;
                    for (int m = 0; m < N; m++) mq[d][m].delete();
                end else begin
                    for (int m = 0; m < N; m++) begin
                        if (hs[d][m]) begin
                            if (mq[d][m].size() > 0) void'(mq[d][m].pop_front());
                            if (mq[d][m].size() > 0 && !mq[d][m][0].gap) present(d, m);
                            else valid[d][m] = 1'b0;
                        end else if (!valid[d][m] && mq[d][m].size() > 0) begin
                            present(d, m);
                        end
                        if (tog[d] && !valid[d][m]) addr[d][m*AW +: AW] = $urandom;
                    end
                end
            end
        end
    end

    // Monitor: every master handshake must match the next expected grant.
    initial begin : p_monitor
        logic [N-1:0] h;
        logic [N-1:0] oh;
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                h = valid[d] & ready[d];
                if (!rst[d] && h != '0) begin
                    if (sq[d].size() == 0) begin
                        check($sformatf("d%0d_unexpected_hs", d), 64'(h), 64'd0);
                    end else begin
                        e = sq[d].pop_front();
                        oh = '0;
                        oh[e.g] = 1'b1;
                        check($sformatf("d%0d_ready", d), 64'(ready[d]), 64'(oh));
                        check($sformatf("d%0d_grant", d), 64'(currmaster[d]), 64'(e.g));
                        if (!e.abort) begin
                            check($sformatf("d%0d_svalid", d), 64'(s_valid[d]), 64'd1);
                            check($sformatf("d%0d_saddr", d), 64'(s_addr[d]), 64'(e.addr));
                            check($sformatf("d%0d_swdata", d), 64'(s_wdata[d]), 64'(e.wdata));
                            check($sformatf("d%0d_swen", d), 64'(s_wen[d]), 64'(e.wen));
                            check($sformatf("d%0d_rdata", d), 64'(rdata[d][e.g*DW +: DW]), 64'(e.addr ^ RK));
                        end else begin
                            check($sformatf("d%0d_abort_svalid", d), 64'(s_valid[d]), 64'd0);
                            check($sformatf("d%0d_abort_rdata", d), 64'(rdata[d][e.g*DW +: DW]), 64'hFFFF_FFFF);
                        end
                    end
                end
            end
        end
    end

    task automatic push(input int d, input int m, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] we, input bit gap);
        txn_t t;
        t.addr = a; t.wdata = wd; t.wen = we; t.gap = gap;
        mq[d][m].push_back(t);
    endtask

    task automatic expect_g(input int d, input int g, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] we, input bit ab);
        exp_t e;
        e.g = g; e.addr = a; e.wdata = wd; e.wen = we; e.abort = ab;
        sq[d].push_back(e);
    endtask

    function automatic bit pending(input int d);
        bit p;
        p = (sq[d].size() != 0) || busy[d] || (valid[d] != '0);
        for (int m = 0; m < N; m++) if (mq[d][m].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input int d, input string nm);
        int c;
        c = 0;
        while (pending(d) && c < 200) begin
            @(negedge clk);
            c++;
        end
        check(nm, 64'(c < 200), 64'd1);
    endtask

    logic [31:0] a;
    int idle, bad, stalls, c;
    bit started, relnext;

    initial begin : p_stim
        rst[0] = 1'b1; rst[1] = 1'b1;
        slat[0] = 0; slat[1] = 1;
        tog[0] = 1'b0; tog[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_busy%0d", d), 64'(busy[d]), 64'd0);
            check($sformatf("rst_cm%0d", d), 64'(currmaster[d]), 64'd0);
            check($sformatf("rst_svalid%0d", d), 64'(s_valid[d]), 64'd0);
            check($sformatf("rst_ready%0d", d), 64'(ready[d]), 64'd0);
            check($sformatf("rst_err%0d", d), 64'(err[d]), 64'd0);
        end

        // Round-robin: all three request twice, gap cycle between each master's pair.
        for (int k = 0; k < 2; k++)
            for (int m = 0; m < N; m++) begin
                a = 32'h1000 + 32'(m * 16 + k * 8);
                push(0, m, a, a ^ 32'hFFFF, 4'(m + 1), 1'b1);
            end
        for (int k = 0; k < 2; k++)
            for (int g = 0; g < N; g++) begin
                a = 32'h1000 + 32'(g * 16 + k * 8);
                expect_g(0, g, a, a ^ 32'hFFFF, 4'(g + 1), 1'b0);
            end
        idle = 0; started = 1'b0; c = 0;
        while (sq[0].size() != 0 && c < 80) begin
            @(negedge clk);
            c++;
            if (busy[0]) started = 1'b1;
            if (started && !busy[0] && sq[0].size() != 0) idle++;
        end
        check("rr_no_idle", 64'(idle), 64'd0);
        drain(0, "rr_drain");

        // Single read from master 0, slave answers 2 cycles after s_valid.
        slat[0] = 2;
        push(0, 0, 32'h100, 32'h0, 4'h0, 1'b1);
        expect_g(0, 0, 32'h100, 32'h0, 4'h0, 1'b0);
        @(negedge clk); check("t1_lat_svalid0", 64'(s_valid[0]), 64'd0);
        @(negedge clk); check("t1_lat_svalid1", 64'(s_valid[0]), 64'd1);
                        check("t1_busy1", 64'(busy[0]), 64'd1);
        @(negedge clk); check("t1_stall_ready", 64'(ready[0]), 64'd0);
        @(negedge clk); check("t1_ready", 64'(ready[0]), 64'b001);
        @(negedge clk); check("t1_rel_busy", 64'(busy[0]), 64'd1);
                        check("t1_rel_svalid", 64'(s_valid[0]), 64'd0);
        @(negedge clk); check("t1_busy_drop", 64'(busy[0]), 64'd0);
        drain(0, "t1_drain");

        // Write then back-to-back read from master 1 while idle masters' addr toggles.
        slat[0] = 3;
        tog[0] = 1'b1;
        push(0, 1, 32'h2000_0040, 32'hA5A5_1234, 4'b0011, 1'b1);
        push(0, 1, 32'h2000_0044, 32'h0, 4'b0000, 1'b0);
        expect_g(0, 1, 32'h2000_0040, 32'hA5A5_1234, 4'b0011, 1'b0);
        expect_g(0, 1, 32'h2000_0044, 32'h0, 4'b0000, 1'b0);
        bad = 0; c = 0;
        while (sq[0].size() != 0 && c < 60) begin
            @(negedge clk);
            #1;
            c++;
            if (s_valid[0] && s_addr[0] != 32'h2000_0040 && s_addr[0] != 32'h2000_0044) bad++;
            if (busy[0] && currmaster[0] != 2'd1) bad++;
        end
        check("wr_addr_isolation", 64'(bad), 64'd0);
        drain(0, "wr_drain");
        tog[0] = 1'b0;

        // Fixed priority: masters 0 and 2 together, then all three together.
        push(1, 0, 32'h300, 32'h11, 4'h1, 1'b1);
        push(1, 2, 32'h320, 32'h22, 4'h2, 1'b1);
        expect_g(1, 2, 32'h320, 32'h22, 4'h2, 1'b0);
        expect_g(1, 0, 32'h300, 32'h11, 4'h1, 1'b0);
        bad = 0; idle = 0; started = 1'b0; relnext = 1'b0; c = 0;
        while (sq[1].size() != 0 && c < 60) begin
            @(negedge clk);
            c++;
            if (relnext) begin
                check("fp_handover", 64'(currmaster[1]), 64'd0);
                relnext = 1'b0;
            end
            if (busy[1] && currmaster[1] == 2'd2 && !valid[1][2]) relnext = 1'b1;
            if (busy[1] && currmaster[1] == 2'd2 && ready[1][0]) bad++;
            if (busy[1]) started = 1'b1;
            if (started && !busy[1] && sq[1].size() != 0) idle++;
        end
        check("fp_loser_ready", 64'(bad), 64'd0);
        check("fp_no_idle", 64'(idle), 64'd0);
        drain(1, "fp_drain1");
        for (int m = 0; m < N; m++) push(1, m, 32'h3400 + 32'(m * 4), 32'(m), 4'hF, 1'b1);
        for (int g = 2; g >= 0; g--) expect_g(1, g, 32'h3400 + 32'(g * 4), 32'(g), 4'hF, 1'b0);
        drain(1, "fp_drain3");

        // Asynchronous reset during a stalled grant, then a normal access.
        slat[0] = 100;
        push(0, 2, 32'h400, 32'h0, 4'h0, 1'b1);
        c = 0;
        while (!s_valid[0] && c < 10) begin @(negedge clk); c++; end
        check("arst_reached_grant", 64'(s_valid[0]), 64'd1);
        #2;
        rst[0] = 1'b1;
        sq[0].delete();
        #1;
        check("arst_svalid", 64'(s_valid[0]), 64'd0);
        check("arst_busy", 64'(busy[0]), 64'd0);
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        slat[0] = 1;
        push(0, 1, 32'h500, 32'h0, 4'h0, 1'b1);
        expect_g(0, 1, 32'h500, 32'h0, 4'h0, 1'b0);
        drain(0, "arst_drain");

`ifdef ARBITER_TIMEOUT_EN
        // Slave never answers: abort after 4 stall cycles, err sticks afterwards.
        slat[0] = 100;
        push(0, 0, 32'h600, 32'h0, 4'h0, 1'b1);
        expect_g(0, 0, 32'h600, 32'h0, 4'h0, 1'b1);
        c = 0;
        while (!s_valid[0] && c < 10) begin @(negedge clk); c++; end
        stalls = 0;
        while (!ready[0][0] && stalls < 20) begin @(negedge clk); stalls++; end
        check("to_cycles", 64'(stalls), 64'd4);
        @(negedge clk);
        check("to_err", 64'(err[0]), 64'd1);
        drain(0, "to_drain");
        slat[0] = 0;
        push(0, 1, 32'h700, 32'h0, 4'h0, 1'b1);
        expect_g(0, 1, 32'h700, 32'h0, 4'h0, 1'b0);
        drain(0, "to_good_drain");
        check("to_err_sticky", 64'(err[0]), 64'd1);
`else
        check("err_off0", 64'(err[0]), 64'd0);
`endif
        check("err_off1", 64'(err[1]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
